// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_pkg
//  Description : Shared constants and types for the multi-port register file
//                (regfile_mp) and its busy-bit scoreboard.
//                Contents:
//                  DEFAULT_DW    - default data width
//                  DEFAULT_DEPTH - default register count
//                  DEFAULT_AW    - address width matching DEFAULT_DEPTH
//                  DEFAULT_NRD   - default number of read ports
//                  reg_addr_t    - register address type at default depth
//  Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int DEFAULT_DW    = 32;
    localparam int DEFAULT_DEPTH = 32;
    localparam int DEFAULT_AW    = $clog2(DEFAULT_DEPTH);
    localparam int DEFAULT_NRD   = 2;

    typedef logic [DEFAULT_AW-1:0] reg_addr_t;

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_scoreboard
//  Description : One busy bit per register. A bit is set when a producer is
//                issued for that register and cleared when a write lands on
//                it. A set and a clear aimed at the same register in the same
//                cycle leave it busy (the new producer is still in flight).
//                Register 0 is hardwired and never reports busy.
//  Ports       :
//    clk          in   clock, rising edge
//    rst          in   asynchronous active-high reset, clears all busy bits
//    set_en_i     in   mark set_addr_i busy at the next edge
//    set_addr_i   in   register to mark busy
//    clr0_en_i    in   clear clr0_addr_i at the next edge (write port 0)
//    clr0_addr_i  in   register written by write port 0
//    clr1_en_i    in   clear clr1_addr_i at the next edge (write port 1)
//    clr1_addr_i  in   register written by write port 1
//    lk_addr_i    in   NRD packed lookup addresses, port i at [i*AW +: AW]
//    lk_busy_o    out  NRD busy flags, combinational lookup of the stored bits
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_scoreboard #(
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH),
    parameter int NRD   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              set_en_i,
    input  logic [AW-1:0]     set_addr_i,
    input  logic              clr0_en_i,
    input  logic [AW-1:0]     clr0_addr_i,
    input  logic              clr1_en_i,
    input  logic [AW-1:0]     clr1_addr_i,
    input  logic [NRD*AW-1:0] lk_addr_i,
    output logic [NRD-1:0]    lk_busy_o
);

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    // Clears are applied before the set so that a same-cycle set wins.
    always_comb begin
        busy_d = busy_q;
        if (clr0_en_i) begin
            busy_d[clr0_addr_i] = 1'b0;
        end
        if (clr1_en_i) begin
            busy_d[clr1_addr_i] = 1'b0;
        end
        if (set_en_i) begin
            busy_d[set_addr_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    generate
        for (genvar i = 0; i < NRD; i++) begin : g_lk
            assign lk_busy_o[i] = busy_q[lk_addr_i[i*AW +: AW]];
        end
    endgenerate

endmodule : regfile_scoreboard
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_mp
//  Description : Multi-port register file with two write ports, NRD
//                combinational read ports and a per-register busy scoreboard.
//                Register 0 is hardwired to zero and never busy. When both
//                write ports hit the same register, port 1 wins.
//  Build option: define REGFILE_BYPASS_EN to forward same-cycle write data
//                (and the resulting not-busy status) to the read ports.
//                Without it, a write becomes visible the cycle after its edge.
//  Ports       :
//    clk      in   clock, rising edge
//    rst      in   asynchronous active-high reset
//    ra       in   NRD*AW read addresses, port i at [i*AW +: AW]
//    rd       out  NRD*DW read data, port i at [i*DW +: DW]
//    rd_busy  out  NRD busy flags for the addressed registers
//    we0/we1  in   write enables
//    wa0/wa1  in   write addresses
//    wd0/wd1  in   write data
//    bs_en    in   mark bs_addr busy (producer issued)
//    bs_addr  in   register to mark busy
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DW    = DEFAULT_DW,
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = $clog2(DEPTH),
    parameter int NRD   = DEFAULT_NRD
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NRD*AW-1:0] ra,
    output logic [NRD*DW-1:0] rd,
    output logic [NRD-1:0]    rd_busy,
    input  logic              we0,
    input  logic [AW-1:0]     wa0,
    input  logic [DW-1:0]     wd0,
    input  logic              we1,
    input  logic [AW-1:0]     wa1,
    input  logic [DW-1:0]     wd1,
    input  logic              bs_en,
    input  logic [AW-1:0]     bs_addr
);

    // ------------------------------------------------------------------------
    // Write qualification: register 0 never takes a write.
    // ------------------------------------------------------------------------
    logic wr0_en;
    logic wr1_en;

    assign wr0_en = we0 && (wa0 != '0);
    assign wr1_en = we1 && (wa1 != '0);

    // ------------------------------------------------------------------------
    // Storage. Port 1 is applied last so it overrides port 0 on a collision.
    // Entry 0 is never written and therefore stays at its reset value of 0.
    // ------------------------------------------------------------------------
    logic [DW-1:0] regs_q [DEPTH];
    logic [DW-1:0] regs_d [DEPTH];

    always_comb begin
        regs_d = regs_q;
        if (wr0_en) begin
            regs_d[wa0] = wd0;
        end
        if (wr1_en) begin
            regs_d[wa1] = wd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                regs_q[k] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // ------------------------------------------------------------------------
    // Busy scoreboard. Any enabled write clears the target's busy bit; the
    // scoreboard pins entry 0 to not-busy on its own.
    // ------------------------------------------------------------------------
    logic [NRD-1:0] sb_busy;

    regfile_scoreboard #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .NRD   (NRD)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .set_en_i    (bs_en),
        .set_addr_i  (bs_addr),
        .clr0_en_i   (we0),
        .clr0_addr_i (wa0),
        .clr1_en_i   (we1),
        .clr1_addr_i (wa1),
        .lk_addr_i   (ra),
        .lk_busy_o   (sb_busy)
    );

    // ------------------------------------------------------------------------
    // Read ports.
    // ------------------------------------------------------------------------
    generate
        for (genvar i = 0; i < NRD; i++) begin : g_rd
            logic [AW-1:0] rd_addr;
            logic [DW-1:0] rd_val;
            logic          busy_val;

            assign rd_addr = ra[i*AW +: AW];

            always_comb begin
                rd_val   = regs_q[rd_addr];
                busy_val = sb_busy[i];
`ifdef REGFILE_BYPASS_EN
                // wr*_en already excludes register 0, so r0 never forwards.
                // A forwarded register is about to be written and so is not
                // busy, unless a new producer is issued for it in this cycle.
                if (wr1_en && (wa1 == rd_addr)) begin
                    rd_val   = wd1;
                    busy_val = bs_en && (bs_addr == rd_addr);
                end else if (wr0_en && (wa0 == rd_addr)) begin
                    rd_val   = wd0;
                    busy_val = bs_en && (bs_addr == rd_addr);
                end
`endif
                // Outputs are forced quiet for the whole reset window,
                // including any forwarded write data.
                if (rst) begin
                    rd_val   = '0;
                    busy_val = 1'b0;
                end
            end

            assign rd[i*DW +: DW] = rd_val;
            assign rd_busy[i]     = busy_val;
        end
    endgenerate

endmodule : regfile_mp
`default_nettype wire
